// File: rtl/row_min_driver.sv
`default_nettype none
// ============================================================================
//  Module   : row_min_driver
//  Brief    : Packs 16-bit scores into 8-lane chunks, drives start/done
//             transactions against a min finder and folds the partial
//             results into one row minimum on a valid/ready port.
//  Options  : ROW_MIN_TIMEOUT_EN - abort a chunk (sticky err) when fm_done
//             does not arrive within TIMEOUT_CYCLES of fm_start rising.
//  Revision : 1.0 - initial release
// ============================================================================
module row_min_driver #(
  parameter int ROW_CHUNKS     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] fm_numbers,
  output logic         fm_start,
  input  logic [15:0]  fm_result,
  input  logic         fm_done,
  output logic [15:0]  row_min,
  output logic         row_min_valid,
  input  logic         row_min_ready,
  output logic         busy
`ifdef ROW_MIN_TIMEOUT_EN
  ,
  output logic         err
`endif
);

  localparam logic [1:0] c_FILL    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;
  localparam logic [1:0] c_OUT     = 2'd3;

  localparam logic [7:0]  c_LAST_CHUNK = 8'(ROW_CHUNKS - 1);
  localparam logic [15:0] c_ACC_INIT   = 16'hFFFF;

  // Reject out-of-range configurations at elaboration time.
  if (ROW_CHUNKS < 1 || ROW_CHUNKS > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("row_min_driver: ROW_CHUNKS must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]   state_q, state_d;
  logic [2:0]   lane_q, lane_d;
  logic [7:0]   chunk_q, chunk_d;
  logic [15:0]  acc_q, acc_d;
  logic [127:0] numbers_q, numbers_d;
  logic         start_q, start_d;
  logic [15:0]  row_min_q, row_min_d;
  logic         valid_q, valid_d;
  logic         s_ready_q, s_ready_d;
  logic         busy_q, busy_d;
  logic         w_xfer;

`ifdef ROW_MIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // s_ready is registered, so it already reflects the state we are in.
  assign w_xfer = s_valid && s_ready_q;

  // Next-state logic for the fill / issue / release / output sequence.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    chunk_d   = chunk_q;
    acc_d     = acc_q;
    numbers_d = numbers_q;
    start_d   = start_q;
    row_min_d = row_min_q;
    valid_d   = valid_q;
`ifdef ROW_MIN_TIMEOUT_EN
    tmo_d     = '0;
    err_d     = err_q;
`endif
    case (state_q)
      c_FILL: begin
        if (w_xfer) begin
          numbers_d[{lane_q, 4'b0000} +: 16] = s_data;
          lane_d = lane_q + 3'd1;
          if (lane_q == 3'd7) begin
            start_d = 1'b1;
            state_d = c_ISSUE;
          end
        end
      end
      c_ISSUE: begin
        if (fm_done) begin
          acc_d   = (fm_result < acc_q) ? fm_result : acc_q;
          start_d = 1'b0;
          state_d = c_RELEASE;
        end
`ifdef ROW_MIN_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this row: behave as after reset, but keep err.
          start_d = 1'b0;
          err_d   = 1'b1;
          acc_d   = c_ACC_INIT;
          lane_d  = 3'd0;
          chunk_d = 8'd0;
          state_d = c_FILL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      c_RELEASE: begin
        // fm_start is low for this cycle so the min finder can clear.
        chunk_d = chunk_q + 8'd1;
        if (chunk_q == c_LAST_CHUNK) begin
          row_min_d = acc_q;
          valid_d   = 1'b1;
          state_d   = c_OUT;
        end else begin
          state_d = c_FILL;
        end
      end
      default: begin
        if (row_min_ready) begin
          valid_d = 1'b0;
          acc_d   = c_ACC_INIT;
          chunk_d = 8'd0;
          state_d = c_FILL;
        end
      end
    endcase
    s_ready_d = (state_d == c_FILL);
    busy_d    = !((state_d == c_FILL) && (lane_d == 3'd0) && (chunk_d == 8'd0));
  end

  // State and output registers; reset drops fm_start and discards the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_FILL;
      lane_q    <= 3'd0;
      chunk_q   <= 8'd0;
      acc_q     <= c_ACC_INIT;
      numbers_q <= '0;
      start_q   <= 1'b0;
      row_min_q <= 16'd0;
      valid_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ROW_MIN_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      chunk_q   <= chunk_d;
      acc_q     <= acc_d;
      numbers_q <= numbers_d;
      start_q   <= start_d;
      row_min_q <= row_min_d;
      valid_q   <= valid_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
`ifdef ROW_MIN_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign s_ready       = s_ready_q;
  assign fm_numbers    = numbers_q;
  assign fm_start      = start_q;
  assign row_min       = row_min_q;
  assign row_min_valid = valid_q;
  assign busy          = busy_q;
`ifdef ROW_MIN_TIMEOUT_EN
  assign err           = err_q;
`endif

endmodule
`default_nettype wire

// File: doc/row_min_driver.md
Name: row_min_driver

Overview:
- Initiator side of the 8-lane, 16-bit minimum-finder start/done interface used in the attention datapath.
- Accepts a stream of 16-bit unsigned attention scores and packs each group of 8 into a 128-bit vector.
- Drives start/done transactions against the min finder and folds the partial results into one row minimum.
- Presents that row minimum to downstream softmax/normalisation logic on a valid/ready port.

Parameters:
- ROW_CHUNKS, 4, number of 8-element chunks per row (row length = 8*ROW_CHUNKS); legal range 1..255.
- TIMEOUT_CYCLES, 16, cycles to wait for fm_done before aborting; used only with the optional feature.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  16  score element, unsigned.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block accepts s_data this cycle.
- fm_numbers  output  128  packed chunk to the min finder; lane k at bits [16k+15:16k].
- fm_start  output  1  min-finder start; held high until fm_done is sampled high.
- fm_result  input  16  min-finder result.
- fm_done  input  1  min-finder completion.
- row_min  output  16  minimum of the completed row.
- row_min_valid  output  1  row_min valid.
- row_min_ready  input  1  downstream accepts row_min.
- busy  output  1  high in any state except FILL with lane count 0 and chunk count 0.
- err  output  1  timeout flag; present only with ROW_MIN_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0: fm_numbers, fm_start, row_min, row_min_valid, busy, err.
  - s_ready is 0 while rst_n is low.
  - Internal state: accumulator = 16'hFFFF, lane counter = 0, chunk counter = 0, state = FILL.
  - Reset mid-transaction drops fm_start immediately and discards the partial row.
- All outputs are registered; the handshake is valid/ready with transfer on valid && ready.
- FILL:
  - s_ready = 1.
  - Each accepted element is written into lane[lane counter], and the lane counter increments (3-bit).
  - The transfer of lane 7 moves the block to ISSUE; fm_start goes high on the next cycle, with fm_numbers already stable.
- ISSUE:
  - s_ready = 0; fm_start = 1; fm_numbers frozen.
  - Wait for fm_done = 1; the done handshake takes at least 5 cycles.
  - On the edge where fm_done is sampled high: accumulator <= min(accumulator, fm_result) (unsigned compare), fm_start <= 0, go to RELEASE.
- RELEASE:
  - One cycle with fm_start = 0, so the min finder clears between chunks.
  - Chunk counter increments.
  - If it was chunk ROW_CHUNKS-1: row_min <= accumulator, row_min_valid <= 1, go to OUT. Otherwise go to FILL.
- OUT:
  - s_ready = 0; row_min and row_min_valid held stable until row_min_ready = 1.
  - On transfer: row_min_valid <= 0, accumulator <= 16'hFFFF, chunk counter <= 0, go to FILL.
  - Rows never overlap: there is no acceptance of the next row during OUT.
- Latency from the last element of a row to row_min_valid = ROW_CHUNKS-th done response + 2 cycles.
- fm_done high outside ISSUE is ignored.
- Equal values: either value may be selected; the result is identical.
- Partial chunk: input stalls (s_valid low) simply hold FILL; the lane counter does not wrap until 8 elements are accepted.

Optional Feature:
- Macro ROW_MIN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE.
  - If fm_done is not seen within TIMEOUT_CYCLES cycles of fm_start rising: fm_start <= 0, err <= 1 (sticky until reset), and the partial row is discarded.
  - The accumulator and counters are reinitialised as after reset, and the block returns to FILL; no row_min_valid is issued for the aborted row.
- Not defined: there is no err port and no counter; ISSUE waits indefinitely.

Test Plan:
- Stream 32 elements 100..131 with element 19 replaced by 7, s_valid always high -> four start/done transactions, fm_numbers lane 3 of chunk 2 = 7, row_min = 7, row_min_valid high 1 cycle with ready high.
- Row of 32 x 16'hFFFF -> row_min = 16'hFFFF; row with a single 0 at index 31 -> row_min = 0.
- s_valid toggled every other cycle -> same row_min as the first scenario; fm_start rises only after 8 transfers; s_ready is 0 throughout ISSUE/RELEASE.
- row_min_ready held low 10 cycles -> row_min/row_min_valid stable, s_ready 0; after ready the next row (all 500) gives row_min = 500, not min with the previous row.
- rst_n pulsed low during ISSUE of chunk 1 -> fm_start and all outputs 0 within the same cycle; the next full row yields the correct minimum.
- With ROW_MIN_TIMEOUT_EN, fm_done tied low -> fm_start falls 16 cycles after rising, err = 1, no row_min_valid; without the macro, fm_start stays high indefinitely.
